// File: rtl/run_length_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : run_length_detector_if
// Description : Bundles the sample, threshold, status and statistics signals
//               of run_length_detector. The master modport drives the stream
//               and the control inputs. The slave modport is the detector.
//               EN, IN       : sample enable and serial data bit
//               THR_WE/DIN   : threshold write
//               CLR_STATS    : statistics clear
//               OUT, DET     : run qualifies / one-cycle detection pulse
//               RUN_BIT/CNT  : current run polarity and length
//               STATE        : 00 IDLE, 01 RUN0, 10 RUN1
//               ZERO_RUNS, ONE_RUNS : detected-run statistics
// Revision    : 1.0 - initial release
// ============================================================================
interface run_length_detector_if #(
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16
);
  logic              EN;
  logic              IN;
  logic              THR_WE;
  logic [CNT_W-1:0]  THR_DIN;
  logic              CLR_STATS;
  logic              OUT;
  logic              DET;
  logic              RUN_BIT;
  logic [CNT_W-1:0]  RUN_CNT;
  logic [1:0]        STATE;
  logic [STAT_W-1:0] ZERO_RUNS;
  logic [STAT_W-1:0] ONE_RUNS;

  modport master (
    output EN, IN, THR_WE, THR_DIN, CLR_STATS,
    input  OUT, DET, RUN_BIT, RUN_CNT, STATE, ZERO_RUNS, ONE_RUNS
  );

  modport slave (
    input  EN, IN, THR_WE, THR_DIN, CLR_STATS,
    output OUT, DET, RUN_BIT, RUN_CNT, STATE, ZERO_RUNS, ONE_RUNS
  );
endinterface
`default_nettype wire

// File: rtl/run_length_detector.sv
`default_nettype none
// ============================================================================
// Module      : run_length_detector
// Description : Tracks the length of the current run of identical bits on a
//               serial stream with a saturating counter. OUT is high while
//               the run length is at or above a runtime threshold. DET pulses
//               for one cycle each time a run first qualifies.
// Ports       : CLK   - clock, rising edge
//               RESET - synchronous, active-low reset
//               bus   - run_length_detector_if.slave (stream, threshold,
//                       status and statistics signals)
// Options     : define RUN_DET_STATS_EN to build the ZERO_RUNS / ONE_RUNS
//               detection counters. Without it they read as 0 and CLR_STATS
//               is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module run_length_detector #(
  parameter int CNT_W      = 8,
  parameter int DEF_THRESH = 4,
  parameter int STAT_W     = 16
) (
  input  wire logic             CLK,
  input  wire logic             RESET,
  run_length_detector_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN0 = 2'b01,
    ST_RUN1 = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max    = '1;
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  // A zero threshold is never held. Treat a zero default like a zero write.
  localparam logic [CNT_W-1:0] c_def_thresh =
    (DEF_THRESH == 0) ? CNT_W'(1) : CNT_W'(DEF_THRESH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_thresh;
  logic             r_run_bit;
  logic             r_out;
  logic             r_det;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_bit_next;
  logic             w_out_next;
  logic             w_det_next;

  // Next run state. These values are used only on EN edges.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_RUN0, ST_RUN1: begin
        if (bus.IN == (r_state == ST_RUN1)) begin
          w_cnt_next = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + c_cnt_one;
        end else begin
          w_state_next = bus.IN ? ST_RUN1 : ST_RUN0;
          w_cnt_next   = c_cnt_one;
        end
      end
      default: begin
        // IDLE, and recovery from the unused encoding: start a new run.
        w_state_next = bus.IN ? ST_RUN1 : ST_RUN0;
        w_cnt_next   = c_cnt_one;
      end
    endcase
    w_bit_next = (w_state_next == ST_RUN1);
    w_out_next = (w_state_next != ST_IDLE) && (w_cnt_next >= r_thresh);
    // Pulse only when the run was not already qualifying with the same polarity.
    // This covers a polarity switch and a threshold lowered mid-run.
    w_det_next = w_out_next && !(r_out && (r_run_bit == w_bit_next));
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_run_bit <= 1'b0;
      r_out     <= 1'b0;
      r_det     <= 1'b0;
      r_thresh  <= c_def_thresh;
    end else begin
      // The threshold write takes effect from the next EN edge.
      if (bus.THR_WE) begin
        r_thresh <= (bus.THR_DIN == '0) ? c_cnt_one : bus.THR_DIN;
      end
      if (bus.EN) begin
        r_state   <= w_state_next;
        r_cnt     <= w_cnt_next;
        r_run_bit <= w_bit_next;
        r_out     <= w_out_next;
        r_det     <= w_det_next;
      end else begin
        r_det     <= 1'b0;
      end
    end
  end

  assign bus.STATE   = r_state;
  assign bus.RUN_CNT = r_cnt;
  assign bus.RUN_BIT = r_run_bit;
  assign bus.OUT     = r_out;
  assign bus.DET     = r_det;

`ifdef RUN_DET_STATS_EN
  localparam logic [STAT_W-1:0] c_stat_max = '1;
  localparam logic [STAT_W-1:0] c_stat_one = STAT_W'(1);

  logic [STAT_W-1:0] r_zero_runs;
  logic [STAT_W-1:0] r_one_runs;

  // Count on the edge that registers DET, and file the count by the new run's polarity.
  always_ff @(posedge CLK) begin
    if (!RESET || bus.CLR_STATS) begin
      r_zero_runs <= '0;
      r_one_runs  <= '0;
    end else if (bus.EN && w_det_next) begin
      if (w_bit_next) begin
        if (r_one_runs != c_stat_max) r_one_runs <= r_one_runs + c_stat_one;
      end else begin
        if (r_zero_runs != c_stat_max) r_zero_runs <= r_zero_runs + c_stat_one;
      end
    end
  end

  assign bus.ZERO_RUNS = r_zero_runs;
  assign bus.ONE_RUNS  = r_one_runs;
`else
  logic w_unused_clr_stats;
  assign w_unused_clr_stats = bus.CLR_STATS;
  assign bus.ZERO_RUNS      = '0;
  assign bus.ONE_RUNS       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_length_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_length_detector
// Description : Bench for run_length_detector. One DUT uses CNT_W=8 and one
//               uses CNT_W=3. Both receive the same stimulus. A run-length
//               reference model predicts every cycle. The monitor compares
//               the predictions with each DUT's outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_length_detector;

  localparam int DEF_THRESH = 4;
  localparam int STAT_W     = 16;
  localparam int STAT_MAX   = (1 << STAT_W) - 1;

  typedef struct {
    int st;
    int cnt;
    int rbit;
    int out;
    int det;
    int zr;
    int orr;
  } obs_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  run_length_detector_if #(.CNT_W(8), .STAT_W(STAT_W)) if8 ();
  run_length_detector_if #(.CNT_W(3), .STAT_W(STAT_W)) if3 ();

  run_length_detector #(.CNT_W(8), .DEF_THRESH(DEF_THRESH), .STAT_W(STAT_W)) u_dut8 (
    .CLK(CLK), .RESET(RESET), .bus(if8)
  );
  run_length_detector #(.CNT_W(3), .DEF_THRESH(DEF_THRESH), .STAT_W(STAT_W)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .bus(if3)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  obs_t exp_q [2][$];

  // Reference model state per DUT: the run length as a saturated integer.
  int m_started [2];
  int m_bit     [2];
  int m_len     [2];
  int m_thr     [2];
  int m_out     [2];
  int m_det     [2];
  int m_zr      [2];
  int m_or      [2];
  int m_cmax    [2] = '{255, 7};

  task automatic model_step(input int k, input bit rst, input bit en,
                            input bit in, input bit we, input int din, input bit clr);
    obs_t e;
    int prev_bit, prev_out, newout, dinm;
    if (!rst) begin
      m_started[k] = 0; m_bit[k] = 0; m_len[k] = 0; m_thr[k] = DEF_THRESH;
      m_out[k] = 0; m_det[k] = 0; m_zr[k] = 0; m_or[k] = 0;
    end else begin
      dinm = din % (m_cmax[k] + 1);
      if (en) begin
        prev_bit = m_bit[k];
        prev_out = m_out[k];
        if (m_started[k] == 0) begin
          m_started[k] = 1; m_bit[k] = int'(in); m_len[k] = 1;
        end else if (int'(in) == m_bit[k]) begin
          m_len[k] = (m_len[k] + 1 > m_cmax[k]) ? m_cmax[k] : m_len[k] + 1;
        end else begin
          m_bit[k] = int'(in); m_len[k] = 1;
        end
        newout   = (m_len[k] >= m_thr[k]) ? 1 : 0;
        m_det[k] = (newout == 1 && !(prev_out == 1 && prev_bit == m_bit[k])) ? 1 : 0;
        m_out[k] = newout;
      end else begin
        m_det[k] = 0;
      end
`ifdef RUN_DET_STATS_EN
      if (clr) begin
        m_zr[k] = 0; m_or[k] = 0;
      end else if (en && m_det[k] == 1) begin
        if (m_bit[k] == 1) m_or[k] = (m_or[k] < STAT_MAX) ? m_or[k] + 1 : STAT_MAX;
        else               m_zr[k] = (m_zr[k] < STAT_MAX) ? m_zr[k] + 1 : STAT_MAX;
      end
`endif
      if (we) m_thr[k] = (dinm == 0) ? 1 : dinm;
    end
    e.st   = (m_started[k] == 0) ? 0 : (m_bit[k] == 1 ? 2 : 1);
    e.cnt  = m_len[k];
    e.rbit = m_bit[k];
    e.out  = m_out[k];
    e.det  = m_det[k];
    e.zr   = m_zr[k];
    e.orr  = m_or[k];
    exp_q[k].push_back(e);
  endtask

  // Apply inputs at the falling edge. After the rising edge, push the predictions.
  task automatic step(input bit en, input bit in, input bit we = 1'b0,
                      input int din = 0, input bit rst = 1'b1, input bit clr = 1'b0);
    logic [7:0] d8;
    d8 = 8'(din);
    @(negedge CLK);
    RESET         = rst;
    if8.EN        = en;       if3.EN        = en;
    if8.IN        = in;       if3.IN        = in;
    if8.THR_WE    = we;       if3.THR_WE    = we;
    if8.THR_DIN   = d8;       if3.THR_DIN   = d8[2:0];
    if8.CLR_STATS = clr;      if3.CLR_STATS = clr;
    @(posedge CLK);
    model_step(0, rst, en, in, we, int'(d8), clr);
    model_step(1, rst, en, in, we, int'(d8), clr);
  endtask

  task automatic run_bits(input int n, input bit b);
    for (int i = 0; i < n; i++) step(1'b1, b);
  endtask

  task automatic compare(input int k, input obs_t g, input obs_t e);
    tests_run++;
    if (g.st != e.st || g.cnt != e.cnt || g.rbit != e.rbit || g.out != e.out ||
        g.det != e.det || g.zr != e.zr || g.orr != e.orr) begin
      tests_failed++;
      $display("FAIL cycle_check dut%0d #%0d: got st=%0d cnt=%0d bit=%0d out=%0d det=%0d zr=%0d or=%0d, exp st=%0d cnt=%0d bit=%0d out=%0d det=%0d zr=%0d or=%0d",
               k, tests_run, g.st, g.cnt, g.rbit, g.out, g.det, g.zr, g.orr,
               e.st, e.cnt, e.rbit, e.out, e.det, e.zr, e.orr);
    end
  endtask

  // Monitor: the outputs are sampled 1 time unit after each rising edge.
  always @(posedge CLK) begin
    obs_t g, e;
    #1;
    if (exp_q[0].size() > 0) begin
      e = exp_q[0].pop_front();
      g.st = int'(if8.STATE); g.cnt = int'(if8.RUN_CNT); g.rbit = int'(if8.RUN_BIT);
      g.out = int'(if8.OUT); g.det = int'(if8.DET);
      g.zr = int'(if8.ZERO_RUNS); g.orr = int'(if8.ONE_RUNS);
      compare(0, g, e);
    end
    if (exp_q[1].size() > 0) begin
      e = exp_q[1].pop_front();
      g.st = int'(if3.STATE); g.cnt = int'(if3.RUN_CNT); g.rbit = int'(if3.RUN_BIT);
      g.out = int'(if3.OUT); g.det = int'(if3.DET);
      g.zr = int'(if3.ZERO_RUNS); g.orr = int'(if3.ONE_RUNS);
      compare(1, g, e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cur;
    int r;
    RESET = 1'b0;
    if8.EN = 0; if8.IN = 0; if8.THR_WE = 0; if8.THR_DIN = '0; if8.CLR_STATS = 0;
    if3.EN = 0; if3.IN = 0; if3.THR_WE = 0; if3.THR_DIN = '0; if3.CLR_STATS = 0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    // Four 0s qualify, and a fifth 0 gives no repeat pulse.
    run_bits(5, 1'b0);
    // 1,1,1,0,1,1,1,1
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_bits(3, 1'b1); run_bits(1, 1'b0); run_bits(4, 1'b1);
    // Nine 1s saturate the narrow counter.
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_bits(9, 1'b1);
    // Lower the threshold mid-run, then write 0 (effective 1).
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8);
    run_bits(5, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3);
    run_bits(1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0);
    run_bits(1, 1'b1);
    run_bits(1, 1'b0);
    // Outputs hold while EN is low. Then reset lands in the middle of a run.
    step(1'b0, 1'b0, 1'b1, 4);
    run_bits(4, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    run_bits(2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_bits(4, 1'b1);
    // Statistics: two 0-runs and one 1-run, then a clear that coincides with a DET.
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_bits(4, 1'b0); run_bits(4, 1'b1); run_bits(4, 1'b0);
    run_bits(3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    run_bits(2, 1'b1);

    // Random runs: bits mostly repeat, thresholds are small, and resets and clears are rare.
    cur = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) cur = ~cur;
      if (r < 1)
        step(1'b0, cur, 1'b0, 0, 1'b0);
      else if (r < 5)
        step(1'b0, cur, 1'b1, int'($urandom_range(0, 12)));
      else if (r < 7)
        step(1'b1, cur, 1'b0, 0, 1'b1, 1'b1);
      else if (r < 20)
        step(1'b0, cur);
      else
        step(1'b1, cur);
    end

    // Let the monitor consume the remaining predictions within a bounded number of cycles.
    for (int i = 0; i < 10 && (exp_q[0].size() + exp_q[1].size()) > 0; i++) @(negedge CLK);
    if ((exp_q[0].size() + exp_q[1].size()) > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d predictions left unchecked, required 0",
               exp_q[0].size() + exp_q[1].size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
